// File: rtl/ray_hit_pkg.sv
// ray_hit_pkg
//   Shared types and constants for the ray hit accumulator.
//   - hit_lane_t      : one primitive hit record at the default widths
//                       (32-bit signed T, 64-bit opaque payload).
//   - ray_hit_mode_e  : CLOSEST (full reduction) or ANY (shadow-ray early out).
//   - ray_hit_state_e : accumulator control states.
//   - BATCH_BITS      : width of the per-ray batch counter.
package ray_hit_pkg;

  localparam int BATCH_BITS      = 16;
  localparam int RH_T_BITS       = 32;
  localparam int RH_PAYLOAD_BITS = 64;

  typedef struct packed {
    logic                              hit;
    logic signed [RH_T_BITS-1:0]       t;
    logic        [RH_PAYLOAD_BITS-1:0] payload;
  } hit_lane_t;

  typedef enum logic {
    HIT_CLOSEST = 1'b0,
    HIT_ANY     = 1'b1
  } ray_hit_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ray_hit_state_e;

endpackage

// File: rtl/hit_min_tree.sv
// hit_min_tree
//   Combinational min-T selector over WIDTH lanes (WIDTH a power of 2).
//   A log2(WIDTH)-level pairwise compare tree; at every node the left
//   (lower-index) child wins unless the right child is strictly smaller,
//   so ties resolve to the lowest lane index.
// Ports:
//   i_t     : per-lane signed T
//   i_mask  : per-lane qualification
//   o_any   : at least one lane qualified
//   o_min_t : smallest qualified T (don't-care when o_any=0)
//   o_idx   : lane index of o_min_t
module hit_min_tree
  import ray_hit_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int T_BITS   = 32,
  parameter int IDX_BITS = $clog2(WIDTH)
) (
  input  logic signed [T_BITS-1:0]   i_t [WIDTH],
  input  logic        [WIDTH-1:0]    i_mask,
  output logic                       o_any,
  output logic signed [T_BITS-1:0]   o_min_t,
  output logic        [IDX_BITS-1:0] o_idx
);

  localparam int LEVELS = $clog2(WIDTH);

  logic                       w_vld [LEVELS+1][WIDTH];
  logic signed [T_BITS-1:0]   w_t   [LEVELS+1][WIDTH];
  logic        [IDX_BITS-1:0] w_idx [LEVELS+1][WIDTH];

  for (genvar n = 0; n < WIDTH; n++) begin : g_leaf
    assign w_vld[0][n] = i_mask[n];
    assign w_t[0][n]   = i_t[n];
    assign w_idx[0][n] = IDX_BITS'(n);
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    for (genvar n = 0; n < WIDTH; n++) begin : g_node
      if (n < (WIDTH >> (l + 1))) begin : g_cmp
        logic w_pick_r;
        // Right child only wins when it is valid and strictly smaller.
        assign w_pick_r = w_vld[l][2*n+1] &&
                          (!w_vld[l][2*n] || (w_t[l][2*n] > w_t[l][2*n+1]));
        assign w_vld[l+1][n] = w_vld[l][2*n] | w_vld[l][2*n+1];
        assign w_t[l+1][n]   = w_pick_r ? w_t[l][2*n+1]   : w_t[l][2*n];
        assign w_idx[l+1][n] = w_pick_r ? w_idx[l][2*n+1] : w_idx[l][2*n];
      end else begin : g_pad
        assign w_vld[l+1][n] = 1'b0;
        assign w_t[l+1][n]   = '0;
        assign w_idx[l+1][n] = '0;
      end
    end
  end

  assign o_any   = w_vld[LEVELS][0];
  assign o_min_t = w_t[LEVELS][0];
  assign o_idx   = w_idx[LEVELS][0];

endmodule

// File: rtl/ray_hit_accumulator.sv
// ray_hit_accumulator
//   Streams batches of WIDTH primitive hits for one ray, reduces each batch
//   to its min-T qualified lane (stage 1 register, stage 2 tree + merge) and
//   keeps a running best hit. CLOSEST mode returns the overall closest hit
//   after the last batch; ANY mode finishes at the first qualifying batch.
//   Optional: define RAY_HIT_STATS_EN to add saturating statistics outputs
//   stat_batches / stat_lane_hits (merged batches / qualified lanes).
// Ports:
//   clk, resetn                         : clock, async active-low reset
//   start_valid/ready, start_mode/max_t : ray start handshake
//   in_valid/ready, in_last, in_hit,
//   in_t, in_payload                    : batch stream, lane 0 in the LSBs
//   out_valid/ready, out_hit, out_t,
//   out_payload, out_batch, out_lane    : result handshake and best hit
module ray_hit_accumulator
  import ray_hit_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int T_BITS       = 32,
  parameter int PAYLOAD_BITS = 64,
  parameter int IDX_BITS     = $clog2(WIDTH)
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            start_valid,
  output logic                            start_ready,
  input  logic                            start_mode,
  input  logic [T_BITS-1:0]               start_max_t,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_last,
  input  logic [WIDTH-1:0]                in_hit,
  input  logic [WIDTH*T_BITS-1:0]         in_t,
  input  logic [WIDTH*PAYLOAD_BITS-1:0]   in_payload,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_hit,
  output logic [T_BITS-1:0]               out_t,
  output logic [PAYLOAD_BITS-1:0]         out_payload,
  output logic [BATCH_BITS-1:0]           out_batch,
  output logic [IDX_BITS-1:0]             out_lane
`ifdef RAY_HIT_STATS_EN
  ,
  output logic [31:0]                     stat_batches,
  output logic [31:0]                     stat_lane_hits
`endif
);

  function automatic logic [BATCH_BITS-1:0] sat_inc_batch(input logic [BATCH_BITS-1:0] v);
    return (&v) ? v : v + BATCH_BITS'(1);
  endfunction

  // Control and running best
  ray_hit_state_e              r_state;
  ray_hit_mode_e               r_mode;
  logic signed [T_BITS-1:0]    r_max_t;
  logic [BATCH_BITS-1:0]       r_batch_cnt;
  logic                        r_best_hit;
  logic signed [T_BITS-1:0]    r_best_t;
  logic [PAYLOAD_BITS-1:0]     r_best_payload;
  logic [BATCH_BITS-1:0]       r_best_batch;
  logic [IDX_BITS-1:0]         r_best_lane;

  // Stage 1 registers
  logic                        r_vld_p1;
  logic                        r_last_p1;
  logic [WIDTH-1:0]            r_mask_p1;
  logic signed [T_BITS-1:0]    r_t_p1       [WIDTH];
  logic [PAYLOAD_BITS-1:0]     r_payload_p1 [WIDTH];
  logic [BATCH_BITS-1:0]       r_batch_p1;

  logic signed [T_BITS-1:0]    w_in_t [WIDTH];
  logic [WIDTH-1:0]            w_qual;
  logic                        w_tree_any;
  logic signed [T_BITS-1:0]    w_tree_t;
  logic [IDX_BITS-1:0]         w_tree_idx;
  logic                        w_better;
  logic                        w_any_stop;
  logic                        w_accept;

  // Qualification: hit set, 0 < T < max_t (signed).
  for (genvar g = 0; g < WIDTH; g++) begin : g_qual
    assign w_in_t[g] = in_t[g*T_BITS +: T_BITS];
    assign w_qual[g] = in_hit[g] && !w_in_t[g][T_BITS-1] && (w_in_t[g] != '0) &&
                       (w_in_t[g] < r_max_t);
  end

  // ANY mode stops taking batches in the very cycle a hit merges, so
  // nothing accepted behind the winning batch can reach the merge.
  assign w_any_stop  = r_vld_p1 && (r_mode == HIT_ANY) && w_tree_any;
  assign in_ready    = (r_state == ACCUM) && !w_any_stop;
  assign w_accept    = in_valid && in_ready;
  assign start_ready = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign w_better    = r_vld_p1 && w_tree_any && (w_tree_t < r_best_t);

  assign out_hit     = r_best_hit;
  assign out_t       = r_best_t;
  assign out_payload = r_best_payload;
  assign out_batch   = r_best_batch;
  assign out_lane    = r_best_lane;

  // ---- stage 0 -> stage 1: register accepted batch ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
    end else begin
      r_vld_p1  <= w_accept;
      r_last_p1 <= w_accept && in_last;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mask_p1  <= w_qual;
      r_batch_p1 <= r_batch_cnt;
      for (int g = 0; g < WIDTH; g++) begin
        r_t_p1[g]       <= w_in_t[g];
        r_payload_p1[g] <= in_payload[g*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
    end
  end

  hit_min_tree #(
    .WIDTH    (WIDTH),
    .T_BITS   (T_BITS),
    .IDX_BITS (IDX_BITS)
  ) u_tree (
    .i_t     (r_t_p1),
    .i_mask  (r_mask_p1),
    .o_any   (w_tree_any),
    .o_min_t (w_tree_t),
    .o_idx   (w_tree_idx)
  );

  // ---- stage 2: tree result merges into the running best ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state        <= IDLE;
      r_mode         <= HIT_CLOSEST;
      r_max_t        <= '0;
      r_batch_cnt    <= '0;
      r_best_hit     <= 1'b0;
      r_best_t       <= '0;
      r_best_payload <= '0;
      r_best_batch   <= '0;
      r_best_lane    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_valid) begin
            r_mode         <= ray_hit_mode_e'(start_mode);
            r_max_t        <= start_max_t;
            r_best_t       <= start_max_t;
            r_best_hit     <= 1'b0;
            r_best_payload <= '0;
            r_best_batch   <= '0;
            r_best_lane    <= '0;
            r_batch_cnt    <= '0;
            r_state        <= ACCUM;
          end
        end
        ACCUM: begin
          if (w_accept) r_batch_cnt <= sat_inc_batch(r_batch_cnt);
          if (w_any_stop)                r_state <= DONE;
          else if (w_accept && in_last)  r_state <= DRAIN;
        end
        DRAIN: begin
          if (r_vld_p1 && r_last_p1) r_state <= DONE;
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      // Strict less-than keeps the earlier batch on equal T.
      if (w_better) begin
        r_best_hit     <= 1'b1;
        r_best_t       <= w_tree_t;
        r_best_payload <= r_payload_p1[w_tree_idx];
        r_best_batch   <= r_batch_p1;
        r_best_lane    <= w_tree_idx;
      end
    end
  end

`ifdef RAY_HIT_STATS_EN
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  logic [31:0] r_stat_batches;
  logic [31:0] r_stat_lane_hits;

  // Counted at the merge so batches that never merge are not counted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stat_batches   <= '0;
      r_stat_lane_hits <= '0;
    end else if (r_vld_p1) begin
      r_stat_batches   <= sat_add32(r_stat_batches, 32'd1);
      r_stat_lane_hits <= sat_add32(r_stat_lane_hits, 32'($countones(r_mask_p1)));
    end
  end

  assign stat_batches   = r_stat_batches;
  assign stat_lane_hits = r_stat_lane_hits;
`endif

endmodule

// File: tb/tb_ray_hit_accumulator.sv
// tb_ray_hit_accumulator
//   Directed bench for ray_hit_accumulator (WIDTH=4, 32-bit T, 64-bit payload).
//   A transaction-level model keeps the accepted batches of the current ray
//   and derives the expected handshakes and best hit from them; one compare
//   process checks the DUT every cycle, and each scenario also checks
//   hand-computed literal results.
`timescale 1ns/1ps
module tb_ray_hit_accumulator;
  import ray_hit_pkg::*;

  localparam int WIDTH    = 4;
  localparam int TB       = RH_T_BITS;
  localparam int PB       = RH_PAYLOAD_BITS;
  localparam int IDX_BITS = 2;
  localparam int NEVER    = 32'h3FFF_FFFF;

  logic                  clk = 1'b0;
  logic                  resetn = 1'b1;
  logic                  start_valid = 1'b0;
  logic                  start_ready;
  logic                  start_mode = 1'b0;
  logic [TB-1:0]         start_max_t = '0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic                  in_last = 1'b0;
  logic [WIDTH-1:0]      in_hit = '0;
  logic [WIDTH*TB-1:0]   in_t = '0;
  logic [WIDTH*PB-1:0]   in_payload = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic                  out_hit;
  logic [TB-1:0]         out_t;
  logic [PB-1:0]         out_payload;
  logic [15:0]           out_batch;
  logic [IDX_BITS-1:0]   out_lane;
`ifdef RAY_HIT_STATS_EN
  logic [31:0]           stat_batches;
  logic [31:0]           stat_lane_hits;
`endif

  ray_hit_accumulator dut (
    .clk         (clk),
    .resetn      (resetn),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .start_mode  (start_mode),
    .start_max_t (start_max_t),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_last     (in_last),
    .in_hit      (in_hit),
    .in_t        (in_t),
    .in_payload  (in_payload),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_hit     (out_hit),
    .out_t       (out_t),
    .out_payload (out_payload),
    .out_batch   (out_batch),
    .out_lane    (out_lane)
`ifdef RAY_HIT_STATS_EN
    ,
    .stat_batches   (stat_batches),
    .stat_lane_hits (stat_lane_hits)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct packed {
    hit_lane_t [WIDTH-1:0] lane;
    logic [15:0]           num;
  } batch_t;

  batch_t      m_q[$];
  batch_t      m_b;
  bit          m_busy = 0;
  bit          m_mode = 0;
  bit          m_ended = 0;
  bit          m_anyq;
  logic [31:0] m_max_t = '0;
  logic [15:0] m_cnt = '0;
  int          m_stop = NEVER;
  int          m_done = NEVER;
  int          cyc = 0;
  bit          e_in_ready, e_out_valid;
  logic        r_hit;
  logic [31:0] r_t;
  logic [63:0] r_pay;
  logic [15:0] r_bn;
  logic [1:0]  r_ln;

  function automatic bit qual(input hit_lane_t l, input logic [31:0] mx);
    return l.hit && ($signed(l.t) > 0) && ($signed(l.t) < $signed(mx));
  endfunction

  // Closest qualified hit over the accepted batches in order; ANY mode stops
  // at the first batch that contributes a hit.
  function automatic void model_result(output logic h, output logic [31:0] t,
                                       output logic [63:0] p, output logic [15:0] bn,
                                       output logic [1:0] ln);
    h = 0; t = m_max_t; p = '0; bn = '0; ln = '0;
    foreach (m_q[i]) begin
      for (int j = 0; j < WIDTH; j++) begin
        if (qual(m_q[i].lane[j], m_max_t) && ($signed(m_q[i].lane[j].t) < $signed(t))) begin
          h = 1; t = m_q[i].lane[j].t; p = m_q[i].lane[j].payload;
          bn = m_q[i].num; ln = 2'(j);
        end
      end
      if (m_mode && h) break;
    end
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!resetn) begin
        m_busy = 0;
        m_q.delete();
      end
      e_in_ready  = m_busy && !m_ended && (cyc < m_stop);
      e_out_valid = m_busy && (cyc >= m_done);
      check("start_ready", start_ready, !m_busy);
      check("in_ready", in_ready, e_in_ready);
      check("out_valid", out_valid, e_out_valid);
      if (e_out_valid && out_valid) begin
        model_result(r_hit, r_t, r_pay, r_bn, r_ln);
        check("out_hit", out_hit, r_hit);
        check("out_t", out_t, r_t);
        check("out_payload", out_payload, r_pay);
        check("out_batch", out_batch, r_bn);
        check("out_lane", out_lane, r_ln);
      end
      if (resetn) begin
        if (!m_busy) begin
          if (start_valid) begin
            m_busy = 1; m_mode = start_mode; m_max_t = start_max_t;
            m_q.delete(); m_ended = 0; m_stop = NEVER; m_done = NEVER; m_cnt = '0;
          end
        end else if (e_out_valid) begin
          if (out_ready) m_busy = 0;
        end else if (in_valid && e_in_ready) begin
          m_b.num = m_cnt;
          if (m_cnt != 16'hFFFF) m_cnt++;
          m_anyq = 0;
          for (int j = 0; j < WIDTH; j++) begin
            m_b.lane[j].hit     = in_hit[j];
            m_b.lane[j].t       = in_t[j*TB +: TB];
            m_b.lane[j].payload = in_payload[j*PB +: PB];
            if (qual(m_b.lane[j], m_max_t)) m_anyq = 1;
          end
          m_q.push_back(m_b);
          if (in_last) begin
            m_ended = 1; m_done = cyc + 2;
          end
          if (m_mode && m_anyq) begin
            m_stop = cyc + 1; m_done = cyc + 2;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int g_ray = 0;
  int g_bat = 0;

  function automatic logic [63:0] mk_pay(input int ray, input int bat, input int lane);
    return {16'hC0DE, 16'(ray), 16'(bat), 16'(lane)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit mode, input logic [31:0] mx);
    bit got;
    got = 0;
    g_ray++; g_bat = 0;
    start_valid = 1; start_mode = mode; start_max_t = mx;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (start_ready) got = 1;
      step();
    end
    start_valid = 0;
    check("start_timeout", got, 1'b1);
  endtask

  task automatic send_batch(input logic [3:0] hits, input int t0, input int t1,
                            input int t2, input int t3, input bit last);
    bit got;
    got = 0;
    in_valid = 1; in_last = last; in_hit = hits;
    in_t = {32'(t3), 32'(t2), 32'(t1), 32'(t0)};
    in_payload = {mk_pay(g_ray, g_bat, 3), mk_pay(g_ray, g_bat, 2),
                  mk_pay(g_ray, g_bat, 1), mk_pay(g_ray, g_bat, 0)};
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1;
      step();
    end
    g_bat++;
    if (last) begin
      in_valid = 0; in_last = 0;
    end
    check("accept_timeout", got, 1'b1);
  endtask

  task automatic wait_result();
    bit got;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (out_valid) got = 1;
    end
    check("result_timeout", got, 1'b1);
  endtask

  task automatic accept_result();
    step();
    out_ready = 1;
    step();
    out_ready = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start_ready"}, start_ready, 1'b1);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_hit"}, out_hit, 1'b0);
    check({tag, "_out_t"}, out_t, 64'h0);
    check({tag, "_out_payload"}, out_payload, 64'h0);
    check({tag, "_out_batch"}, out_batch, 64'h0);
    check({tag, "_out_lane"}, out_lane, 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 resetn = 0;
    #1 check_reset_outputs("rst0");
    repeat (2) @(posedge clk);
    #1 resetn = 1;
    step();

    // Closest hit across two batches; lane2 of batch0 is unhit despite T=10.
    do_start(1'b0, 32'd100);
    send_batch(4'b1011, 50, 30, 10, 70, 1'b0);
    send_batch(4'b1111, 40, 25, 60, 90, 1'b1);
    @(negedge clk);
    check("t1_valid_n1", out_valid, 1'b0);
    @(negedge clk);
    check("t1_valid_n2", out_valid, 1'b1);
    check("t1_hit", out_hit, 1'b1);
    check("t1_t", out_t, 64'd25);
    check("t1_batch", out_batch, 64'd1);
    check("t1_lane", out_lane, 64'd1);
    check("t1_payload", out_payload, mk_pay(g_ray, 1, 1));
    accept_result();

    // Bounds (T=0, negative, T=max_t rejected) and cross-batch tie.
    do_start(1'b0, 32'd100);
    send_batch(4'b1111, 0, -5, 100, 20, 1'b0);
    send_batch(4'b1111, 20, 50, 60, 70, 1'b1);
    wait_result();
    check("t2_hit", out_hit, 1'b1);
    check("t2_t", out_t, 64'd20);
    check("t2_batch", out_batch, 64'd0);
    check("t2_lane", out_lane, 64'd3);
    check("t2_payload", out_payload, mk_pay(g_ray, 0, 3));
    accept_result();

    // ANY mode: second batch hits, third presented back-to-back is refused.
    do_start(1'b1, 32'd1000);
    send_batch(4'b0000, 10, 10, 10, 10, 1'b0);
    send_batch(4'b0100, 99, 99, 10, 99, 1'b0);
    in_hit = 4'b0001; in_t = {32'd5, 32'd5, 32'd5, 32'd1};
    @(negedge clk);
    check("t3_ready_drop", in_ready, 1'b0);
    step();
    in_valid = 0;
    wait_result();
    check("t3_hit", out_hit, 1'b1);
    check("t3_t", out_t, 64'd10);
    check("t3_batch", out_batch, 64'd1);
    check("t3_lane", out_lane, 64'd2);
    accept_result();

    // Empty ray.
    do_start(1'b0, 32'h7FFF_0000);
    send_batch(4'b0000, 1, 2, 3, 4, 1'b1);
    wait_result();
    check("t4_hit", out_hit, 1'b0);
    check("t4_t", out_t, 64'h7FFF_0000);
    check("t4_payload", out_payload, 64'h0);
    accept_result();

    // ANY mode without a qualifying lane, then backpressure and restart.
    do_start(1'b1, 32'd50);
    send_batch(4'b1111, 60, 50, -1, 0, 1'b1);
    wait_result();
    for (int i = 0; i < 5; i++) begin
      step();
      start_valid = (i == 1);
      start_max_t = 32'd7;
      @(negedge clk);
      check("t5_start_ready", start_ready, 1'b0);
      check("t5_out_valid", out_valid, 1'b1);
      check("t5_out_t", out_t, 64'd50);
      check("t5_out_hit", out_hit, 1'b0);
    end
    step();
    start_valid = 0;
    accept_result();
    do_start(1'b0, 32'd200);
    send_batch(4'b0010, 500, 150, 7, 7, 1'b1);
    wait_result();
    check("t5_restart_t", out_t, 64'd150);
    check("t5_restart_lane", out_lane, 64'd1);
    accept_result();

    // Reset in the middle of a ray.
    do_start(1'b0, 32'd100);
    send_batch(4'b0001, 5, 0, 0, 0, 1'b0);
    send_batch(4'b0001, 5, 0, 0, 0, 1'b0);
    send_batch(4'b0001, 5, 0, 0, 0, 1'b0);
    #2 resetn = 0;
    in_valid = 0;
    #1 check_reset_outputs("rst1");
    repeat (2) @(posedge clk);
    #1 resetn = 1;
    step();
    do_start(1'b0, 32'd100);
    send_batch(4'b1000, 0, 0, 0, 40, 1'b1);
    wait_result();
    check("t6_hit", out_hit, 1'b1);
    check("t6_t", out_t, 64'd40);
    check("t6_batch", out_batch, 64'd0);
    check("t6_lane", out_lane, 64'd3);
    accept_result();
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
